bip_sequencer: RTL and testbench

- Multi-cycle control unit for the 16-bit accumulator CPU datapath.
- Fetches an instruction and decodes the 5-bit opcode.
- Drives the accumulator enable, accumulator/ALU mux selects, PC advance and data-memory strobes.
- Handshakes with a variable-latency data memory, stops on HLT or a memory timeout, and counts retired instructions.

---
 rtl/bip_sequencer_if.sv | 47 ++++
 rtl/bip_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_bip_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_sequencer_if.sv
// Control bus between the bip_sequencer and the CPU datapath / memories.
//   start        : leave IDLE and begin fetching
//   opcode       : instruction opcode field, sampled in DECODE
//   mem_ack      : data memory read data valid
//   rd_instr     : instruction memory read strobe
//   rd_ram       : data memory read request
//   wr_ram       : data memory write strobe
//   wr_acc       : accumulator enable
//   sel_a        : accumulator mux (00 mem, 01 imm, 10 ALU)
//   sel_b        : ALU operand B (0 mem, 1 imm)
//   alu_op       : 0 add, 1 subtract
//   wr_pc        : PC increment pulse
//   halt         : processor halted
//   fault        : sticky illegal-opcode / memory-timeout flag
//   instr_count  : saturating retired-instruction count
// master = sequencer side, slave = datapath/environment side.
interface bip_sequencer_if #(
    parameter int unsigned OPCODE_BITS = 5,
    parameter int unsigned CNT_BITS    = 16
);
    logic                   start;
    logic [OPCODE_BITS-1:0] opcode;
    logic                   mem_ack;
    logic                   rd_instr;
    logic                   rd_ram;
    logic                   wr_ram;
    logic                   wr_acc;
    logic [1:0]             sel_a;
    logic                   sel_b;
    logic                   alu_op;
    logic                   wr_pc;
    logic                   halt;
    logic                   fault;
    logic [CNT_BITS-1:0]    instr_count;

    modport master (
        input  start, opcode, mem_ack,
        output rd_instr, rd_ram, wr_ram, wr_acc, sel_a, sel_b, alu_op,
               wr_pc, halt, fault, instr_count
    );

    modport slave (
        output start, opcode, mem_ack,
        input  rd_instr, rd_ram, wr_ram, wr_acc, sel_a, sel_b, alu_op,
               wr_pc, halt, fault, instr_count
    );
endinterface

// File: rtl/bip_sequencer.sv
// Multi-cycle control unit for the 16-bit accumulator CPU.
// Fetches, decodes a 5-bit opcode, drives accumulator/ALU selects, PC
// advance and data-memory strobes, waits on a variable-latency data memory
// with a timeout, halts on HLT or fault and counts retired instructions.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bip_sequencer_if.master control bus (see interface header)
// All bus outputs are registered and decoded from the next state.
module bip_sequencer #(
    parameter int unsigned OPCODE_BITS    = 5,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bip_sequencer_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef logic [OPCODE_BITS-1:0] op_t;

    localparam op_t OP_HLT  = op_t'(0);
    localparam op_t OP_STO  = op_t'(1);
    localparam op_t OP_LD   = op_t'(2);
    localparam op_t OP_LDI  = op_t'(3);
    localparam op_t OP_ADD  = op_t'(4);
    localparam op_t OP_ADDI = op_t'(5);
    localparam op_t OP_SUB  = op_t'(6);
    localparam op_t OP_SUBI = op_t'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    state_t              state;
    op_t                 opcode_q;
    logic [TW-1:0]       tcnt;
    logic                rd_instr_q;
    logic                rd_ram_q;
    logic                wr_ram_q;
    logic                wr_acc_q;
    logic [1:0]          sel_a_q;
    logic                sel_b_q;
    logic                alu_op_q;
    logic                wr_pc_q;
    logic                halt_q;
    logic                fault_q;
    logic [CNT_BITS-1:0] count_q;

    // {sel_a, sel_b, alu_op} for the EXEC cycle of each accumulator op
    function automatic logic [3:0] exec_sel(input op_t op);
        case (op)
            OP_LD:   return 4'b00_0_0;
            OP_LDI:  return 4'b01_0_0;
            OP_ADD:  return 4'b10_0_0;
            OP_SUB:  return 4'b10_0_1;
            OP_ADDI: return 4'b10_1_0;
            OP_SUBI: return 4'b10_1_1;
            default: return 4'b00_0_0;
        endcase
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + CNT_BITS'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            opcode_q   <= '0;
            tcnt       <= '0;
            rd_instr_q <= 1'b0;
            rd_ram_q   <= 1'b0;
            wr_ram_q   <= 1'b0;
            wr_acc_q   <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= 1'b0;
            alu_op_q   <= 1'b0;
            wr_pc_q    <= 1'b0;
            halt_q     <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            // strobes default low; halt and fault are sticky
            rd_instr_q <= 1'b0;
            rd_ram_q   <= 1'b0;
            wr_ram_q   <= 1'b0;
            wr_acc_q   <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= 1'b0;
            alu_op_q   <= 1'b0;
            wr_pc_q    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_FETCH;
                        rd_instr_q <= 1'b1;
                    end
                end

                S_FETCH: state <= S_DECODE;

                S_DECODE: begin
                    opcode_q <= bus.opcode;
                    case (bus.opcode)
                        OP_HLT: begin
                            state  <= S_HALT;
                            halt_q <= 1'b1;
                        end
                        OP_STO: begin
                            state    <= S_STORE;
                            wr_ram_q <= 1'b1;
                            wr_pc_q  <= 1'b1;
                            count_q  <= sat_inc(count_q);
                        end
                        OP_LD, OP_ADD, OP_SUB: begin
                            state    <= S_MEMRD;
                            rd_ram_q <= 1'b1;
                            tcnt     <= '0;
                        end
                        OP_LDI, OP_ADDI, OP_SUBI: begin
                            state    <= S_EXEC;
                            wr_acc_q <= 1'b1;
                            wr_pc_q  <= 1'b1;
                            {sel_a_q, sel_b_q, alu_op_q} <= exec_sel(bus.opcode);
                            count_q  <= sat_inc(count_q);
                        end
                        default: begin
                            // Illegal opcode retires as a NOP: its PC pulse
                            // rides on the following FETCH cycle.
                            state      <= S_FETCH;
                            rd_instr_q <= 1'b1;
                            wr_pc_q    <= 1'b1;
                            fault_q    <= 1'b1;
                            count_q    <= sat_inc(count_q);
                        end
                    endcase
                end

                S_MEMRD: begin
                    if (bus.mem_ack) begin
                        state    <= S_EXEC;
                        tcnt     <= '0;
                        wr_acc_q <= 1'b1;
                        wr_pc_q  <= 1'b1;
                        {sel_a_q, sel_b_q, alu_op_q} <= exec_sel(opcode_q);
                        count_q  <= sat_inc(count_q);
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        // this cycle is the TIMEOUT_CYCLES-th wait without ack
                        state   <= S_HALT;
                        tcnt    <= '0;
                        halt_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end else begin
                        tcnt     <= tcnt + TW'(1);
                        rd_ram_q <= 1'b1;
                    end
                end

                S_EXEC, S_STORE: begin
                    state      <= S_FETCH;
                    rd_instr_q <= 1'b1;
                end

                S_HALT: state <= S_HALT;

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_instr    = rd_instr_q;
    assign bus.rd_ram      = rd_ram_q;
    assign bus.wr_ram      = wr_ram_q;
    assign bus.wr_acc      = wr_acc_q;
    assign bus.sel_a       = sel_a_q;
    assign bus.sel_b       = sel_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.wr_pc       = wr_pc_q;
    assign bus.halt        = halt_q;
    assign bus.fault       = fault_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_bip_sequencer.sv
// Bench for bip_sequencer: an instruction-level model expands each directed
// instruction into its expected per-cycle output vector; one compare process
// checks every cycle, plus hand-computed literal counts attached to chosen
// cycles. Counter width is narrowed so saturation is reachable.
module tb_bip_sequencer;
    localparam int unsigned OB   = 5;
    localparam int unsigned TO   = 15;
    localparam int unsigned CB   = 4;
    localparam int unsigned CMAX = (1 << CB) - 1;

    localparam logic [OB-1:0] HLT  = 5'd0;
    localparam logic [OB-1:0] STO  = 5'd1;
    localparam logic [OB-1:0] LD   = 5'd2;
    localparam logic [OB-1:0] LDI  = 5'd3;
    localparam logic [OB-1:0] ADD  = 5'd4;
    localparam logic [OB-1:0] ADDI = 5'd5;
    localparam logic [OB-1:0] SUB  = 5'd6;
    localparam logic [OB-1:0] SUBI = 5'd7;
    localparam logic [OB-1:0] ILL  = 5'd31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bip_sequencer_if #(.OPCODE_BITS(OB), .CNT_BITS(CB)) bus ();

    bip_sequencer #(
        .OPCODE_BITS(OB),
        .TIMEOUT_CYCLES(TO),
        .CNT_BITS(CB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic       rd_instr;
        logic       rd_ram;
        logic       wr_ram;
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       alu_op;
        logic       wr_pc;
        logic       halt;
        logic       fault;
    } exp_t;

    typedef struct {
        exp_t        o;
        int unsigned cnt;
        int          lit_cnt;  // -1 = none
        int          lit_rd;   // -1 = none; expected rd_ram run length just ended
    } cyc_t;

    cyc_t q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // instruction-level model state
    int unsigned m_count = 0;
    bit          m_fault = 0;
    bit          m_halt  = 0;
    bit          m_pend  = 0;

    function automatic exp_t base();
        exp_t e;
        e       = '0;
        e.halt  = m_halt;
        e.fault = m_fault;
        return e;
    endfunction

    function automatic void inc();
        if (m_count < CMAX) m_count = m_count + 1;
    endfunction

    task automatic push(input exp_t e, input logic st, input logic [OB-1:0] op,
                        input logic ack, input int lc = -1, input int lr = -1);
        cyc_t c;
        @(posedge clk);
        #1;
        bus.start   = st;
        bus.opcode  = op;
        bus.mem_ack = ack;
        c.o       = e;
        c.cnt     = m_count;
        c.lit_cnt = lc;
        c.lit_rd  = lr;
        q.push_back(c);
    endtask

    task automatic do_reset();
        m_count = 0;
        m_fault = 0;
        m_halt  = 0;
        m_pend  = 0;
        push(base(), 1'b0, '0, 1'b0, 0);
        rst_n = 1'b0;
        push(base(), 1'b0, '0, 1'b0);
        #2 rst_n = 1'b1;
        push(base(), 1'b0, '0, 1'b0);
        push(base(), 1'b0, '0, 1'b0);
    endtask

    task automatic go();
        push(base(), 1'b1, '0, 1'b0);
    endtask

    task automatic hold(input int n, input logic st);
        for (int i = 0; i < n; i++) push(base(), st, '0, 1'b0);
    endtask

    task automatic do_exec(input logic [OB-1:0] op, input int lc, input int lr);
        exp_t e;
        inc();
        e        = base();
        e.wr_acc = 1'b1;
        e.wr_pc  = 1'b1;
        case (op)
            LD:   e.sel_a = 2'd0;
            LDI:  e.sel_a = 2'd1;
            ADD:  e.sel_a = 2'd2;
            SUB:  begin e.sel_a = 2'd2; e.alu_op = 1'b1; end
            ADDI: begin e.sel_a = 2'd2; e.sel_b = 1'b1; end
            SUBI: begin e.sel_a = 2'd2; e.sel_b = 1'b1; e.alu_op = 1'b1; end
            default: ;
        endcase
        push(e, 1'b0, '0, 1'b0, lc, lr);
    endtask

    task automatic fetch_decode(input logic [OB-1:0] op);
        exp_t e;
        bit   p;
        p = m_pend;
        if (m_pend) begin
            m_pend  = 0;
            m_fault = 1;
            inc();
        end
        e          = base();
        e.rd_instr = 1'b1;
        e.wr_pc    = p;
        push(e, 1'b0, '0, 1'b0);
        push(base(), 1'b0, op, 1'b0);
    endtask

    // delay = ack wait cycles for memory ops (-1 = never acknowledged)
    task automatic run(input logic [OB-1:0] op, input int delay = 0,
                       input int lc = -1, input int lr = -1);
        exp_t e;
        bit   acked;
        fetch_decode(op);
        case (op)
            HLT: begin
                m_halt = 1;
                push(base(), 1'b0, '0, 1'b0, lc, lr);
            end
            STO: begin
                inc();
                e        = base();
                e.wr_ram = 1'b1;
                e.wr_pc  = 1'b1;
                push(e, 1'b0, '0, 1'b0, lc, lr);
            end
            LD, ADD, SUB: begin
                acked = 0;
                for (int i = 0; i < int'(TO); i++) begin
                    e        = base();
                    e.rd_ram = 1'b1;
                    push(e, 1'b0, '0, (i == delay));
                    if (i == delay) begin
                        acked = 1;
                        break;
                    end
                end
                if (acked) begin
                    do_exec(op, lc, lr);
                end else begin
                    m_fault = 1;
                    m_halt  = 1;
                    push(base(), 1'b0, '0, 1'b0, lc, lr);
                end
            end
            LDI, ADDI, SUBI: do_exec(op, lc, lr);
            default: m_pend = 1;
        endcase
    endtask

    // compare process
    initial begin
        cyc_t        c;
        exp_t        act;
        int unsigned ncyc   = 0;
        int unsigned rd_run = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                c   = q.pop_front();
                act = {bus.rd_instr, bus.rd_ram, bus.wr_ram, bus.wr_acc, bus.sel_a,
                       bus.sel_b, bus.alu_op, bus.wr_pc, bus.halt, bus.fault};
                checks++;
                if (act !== c.o) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got=%03h want=%03h", ncyc, act, c.o);
                end
                checks++;
                if (32'(bus.instr_count) !== c.cnt) begin
                    errors++;
                    $display("FAIL count cyc=%0d got=%0d want=%0d", ncyc, bus.instr_count, c.cnt);
                end
                if (c.lit_cnt >= 0) begin
                    checks++;
                    if (32'(bus.instr_count) !== 32'(c.lit_cnt)) begin
                        errors++;
                        $display("FAIL lit_count cyc=%0d got=%0d want=%0d", ncyc, bus.instr_count, c.lit_cnt);
                    end
                end
                if (c.lit_rd >= 0) begin
                    checks++;
                    if (rd_run != 32'(c.lit_rd)) begin
                        errors++;
                        $display("FAIL lit_rd_ram_cycles cyc=%0d got=%0d want=%0d", ncyc, rd_run, c.lit_rd);
                    end
                end
                rd_run = (bus.rd_ram === 1'b1) ? rd_run + 1 : 0;
                ncyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.start   = 1'b0;
        bus.opcode  = '0;
        bus.mem_ack = 1'b0;

        // LDI, ADD with 3-cycle ack wait, STO, SUBI, HLT; start ignored once halted
        do_reset();
        go();
        run(LDI, 0, 1);
        run(ADD, 3, -1, 4);
        run(STO);
        run(SUBI, 0, 4);
        run(HLT, 0, 4);
        hold(3, 1'b1);

        // LD never acknowledged: timeout after 15 wait cycles
        do_reset();
        go();
        run(LD, -1, 0, 15);
        hold(3, 1'b1);

        // illegal opcode retires as NOP with fault, then HLT
        do_reset();
        go();
        run(ILL);
        run(HLT, 0, 1);
        hold(2, 1'b0);

        // ack on the limit cycle succeeds, zero-wait ack, remaining selects, saturation
        do_reset();
        go();
        run(LD, 14, -1, 15);
        run(ADDI);
        run(SUB, 0, -1, 1);
        run(STO);
        for (int i = 0; i < 17; i++) run(LDI, 0, (i == 16) ? 15 : -1);

        // reset in the middle of a LD's memory wait
        fetch_decode(LD);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e        = base();
            e.rd_ram = 1'b1;
            push(e, 1'b0, '0, 1'b0);
        end
        do_reset();
        hold(3, 1'b0);
        go();
        run(LDI, 0, 1);
        run(HLT);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
